i2c_line_cond: RTL and testbench
================================

# i2c_line_cond

Input-side line conditioner for the I2C peripheral. It sits between the SCL/SDA pads and the I2C core's `scl_i`/`sda_i` inputs, and consumes the core's drive signals. It synchronises and deglitches both lines and decodes bus events (START, STOP, SCL edges). It also tracks bus-busy with an idle timeout and flags arbitration loss and clock stretching by a remote device.

## Interface
- `FILT_W`, default 4: width of the glitch-filter length and counter.
- `IDLE_W`, default 16: width of the idle-timeout value and counter.
- `clk_i` in 1: the block's only clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `scl_pad_i` in 1: raw SCL from the pad, asynchronous to `clk_i`.
- `sda_pad_i` in 1: raw SDA from the pad, asynchronous to `clk_i`.
- `scl_oe_i` in 1: core SCL output enable.
- `scl_dat_i` in 1: core SCL output data. The core pulls SCL low iff `scl_oe_i & ~scl_dat_i`.
- `sda_oe_i` in 1: core SDA output enable.
- `sda_dat_i` in 1: core SDA output data. Same pull-low rule as SCL.
- `filt_len_i` in FILT_W: glitch-filter length; static while the bus is active.
- `idle_tmo_i` in IDLE_W: idle-timeout length in cycles; 0 disables the timeout.
- `arb_clr_i` in 1: clears `arb_lost_o`.
- `scl_o` in→out 1 (output): filtered SCL, fed to the core's `scl_i`.
- `sda_o` out 1: filtered SDA, fed to the core's `sda_i`.
- `start_o` out 1: one-cycle pulse per START or repeated START.
- `stop_o` out 1: one-cycle pulse per STOP.
- `scl_rise_o` out 1: one-cycle pulse on each filtered SCL rising edge.
- `scl_fall_o` out 1: one-cycle pulse on each filtered SCL falling edge.
- `busy_o` out 1: bus-busy level.
- `timeout_o` out 1: one-cycle pulse when busy is cleared by the idle timeout.
- `arb_lost_o` out 1: sticky arbitration-lost flag.
- `stretch_o` out 1: level, high while a remote device holds SCL low.

## Operation
- **Synchroniser:** each pad input passes through a 2-flop synchroniser; both flops reset to 1.
- **Filter (per line, independent):**
  - Holds a filtered value `f` (reset 1) and a counter `c` (reset 0).
  - If sync == `f`: `c` <= 0.
  - Else if `c` == `filt_len_i`: `f` <= sync and `c` <= 0.
  - Else: `c` <= `c` + 1.
  - `scl_o`/`sda_o` are the `f` flops directly.
- **Event decode:** combinational from `scl_o`/`sda_o` and their one-cycle-delayed copies `scl_d`/`sda_d` (both reset 1).
  - `start_o` = `scl_d & scl_o & sda_d & ~sda_o`.
  - `stop_o` = `scl_d & scl_o & ~sda_d & sda_o`.
  - `scl_rise_o` = `~scl_d & scl_o`; `scl_fall_o` = `scl_d & ~scl_o`.
  - If SCL and SDA change in the same cycle, only the SCL edge is reported; no START or STOP.
- **Busy:**
  - Set on `start_o`, cleared on `stop_o`.
  - The idle counter resets whenever `~(scl_o & sda_o)` or `~busy_o`, and otherwise increments, saturating.
  - If `busy_o` is high, `idle_tmo_i` != 0 and the counter equals `idle_tmo_i - 1`: next cycle `busy_o` <= 0, `timeout_o` pulses and the counter is cleared.
  - A repeated START while busy pulses `start_o`; `busy_o` stays 1.
- **Arbitration:**
  - On `scl_rise_o`, `arb_lost_o` <= 1 when all of the following hold: `busy_o`, the core is not pulling SDA low, and `sda_o` == 0.
  - `arb_clr_i` clears the flag. If clear and set occur in the same cycle, set wins.
- **Stretch:**
  - A saturating counter increments while the core is not pulling SCL low and `scl_o` == 0; otherwise it is 0.
  - `stretch_o` = counter > `filt_len_i` + 3. The margin covers the synchroniser plus filter delay of the core's own release.

## Timing
- **Reset values:**
  - `scl_o`, `sda_o` = 1.
  - `start_o`, `stop_o`, `scl_rise_o`, `scl_fall_o`, `busy_o`, `timeout_o`, `arb_lost_o`, `stretch_o` = 0.
  - All counters = 0.
- **Latency:** a pad change held stable reaches `scl_o`/`sda_o` after `filt_len_i` + 3 rising edges (2 synchroniser + `filt_len_i` + 1 filter). Event pulses coincide with the first cycle of the new filtered value.
- **Glitch rejection:** a pulse shorter than `filt_len_i` + 1 cycles at the synchroniser output never reaches `scl_o`/`sda_o`.
- **Reset mid-transfer:** all state returns to reset values immediately. No START or STOP is emitted on reset exit while the pads are high.
- All outputs except the four event pulses are driven directly by flops.

## Test plan
- **Reset:** reset with both pads high → all outputs hold reset values; no event pulses for 20 cycles after release.
- **Filter:** `filt_len_i`=3. An SDA low pulse of 3 cycles is rejected. A pulse of 5 cycles makes `sda_o` fall 6 cycles after the pad edge.
- **START/STOP and busy:** SDA falls with SCL high → `start_o` pulse and `busy_o`=1. SDA then rises with SCL high → `stop_o` pulse and `busy_o`=0. SCL and SDA toggled together → only `scl_rise_o`/`scl_fall_o`.
- **Idle timeout:** `idle_tmo_i`=10. START, then both lines held high → `timeout_o` pulses and `busy_o` drops exactly 10 cycles after the counter starts. With `idle_tmo_i`=0, `busy_o` stays 1.
- **Arbitration:** busy bus, core releases SDA, pad SDA held low through an SCL rise → `arb_lost_o`=1 and it stays 1. `arb_clr_i` asserted alone clears it. `arb_clr_i` asserted together with a new loss leaves it 1.
- **Stretch:** `filt_len_i`=0, core releases SCL, pad SCL held low for 10 cycles → `stretch_o` rises once the counter exceeds 3 and falls the cycle `scl_o` returns to 1.

Source files
------------

// File: rtl/i2c_line_cond.sv
// I2C input-side line conditioner: pad synchronisation, glitch filtering, bus event
// decode, busy/idle-timeout tracking, arbitration-loss and clock-stretch detection.
module i2c_line_cond #(
  parameter int unsigned FILT_W = 4,
  parameter int unsigned IDLE_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              scl_pad_i,
  input  logic              sda_pad_i,
  input  logic              scl_oe_i,
  input  logic              scl_dat_i,
  input  logic              sda_oe_i,
  input  logic              sda_dat_i,
  input  logic [FILT_W-1:0] filt_len_i,
  input  logic [IDLE_W-1:0] idle_tmo_i,
  input  logic              arb_clr_i,
  output logic              scl_o,
  output logic              sda_o,
  output logic              start_o,
  output logic              stop_o,
  output logic              scl_rise_o,
  output logic              scl_fall_o,
  output logic              busy_o,
  output logic              timeout_o,
  output logic              arb_lost_o,
  output logic              stretch_o
);

  logic scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d;
  logic sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d;
  logic scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic [FILT_W-1:0] scl_c_q, scl_c_d, sda_c_q, sda_c_d;
  logic scl_dly_q, scl_dly_d, sda_dly_q, sda_dly_d;
  logic busy_q, busy_d, timeout_q, timeout_d;
  logic arb_q, arb_d, stretch_q, stretch_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [FILT_W+1:0]   str_cnt_q, str_cnt_d;
  logic [FILT_W+1:0]   str_thr;
  logic core_scl_pull, core_sda_pull, tmo_hit;

  assign core_scl_pull = scl_oe_i & ~scl_dat_i;
  assign core_sda_pull = sda_oe_i & ~sda_dat_i;

  assign start_o    = scl_dly_q & scl_f_q & sda_dly_q & ~sda_f_q;
  assign stop_o     = scl_dly_q & scl_f_q & ~sda_dly_q & sda_f_q;
  assign scl_rise_o = ~scl_dly_q & scl_f_q;
  assign scl_fall_o = scl_dly_q & ~scl_f_q;

  assign str_thr = {2'b00, filt_len_i} + (FILT_W+2)'(3);
  assign tmo_hit = busy_q && (idle_tmo_i != '0) && (idle_q == idle_tmo_i - IDLE_W'(1));

  always_comb begin
    scl_s1_d  = scl_pad_i;
    scl_s2_d  = scl_s1_q;
    sda_s1_d  = sda_pad_i;
    sda_s2_d  = sda_s1_q;
    scl_dly_d = scl_f_q;
    sda_dly_d = sda_f_q;

    scl_f_d = scl_f_q;
    scl_c_d = '0;
    if (scl_s2_q != scl_f_q) begin
      if (scl_c_q == filt_len_i) scl_f_d = scl_s2_q;
      else                       scl_c_d = scl_c_q + FILT_W'(1);
    end

    sda_f_d = sda_f_q;
    sda_c_d = '0;
    if (sda_s2_q != sda_f_q) begin
      if (sda_c_q == filt_len_i) sda_f_d = sda_s2_q;
      else                       sda_c_d = sda_c_q + FILT_W'(1);
    end

    // START takes priority so a repeated START coinciding with a timeout keeps the bus busy
    timeout_d = tmo_hit;
    busy_d    = busy_q;
    if (start_o)              busy_d = 1'b1;
    else if (stop_o || tmo_hit) busy_d = 1'b0;

    idle_d = '0;
    if (!tmo_hit && scl_f_q && sda_f_q && busy_q && (idle_q != '1))
      idle_d = idle_q + IDLE_W'(1);
    else if (!tmo_hit && scl_f_q && sda_f_q && busy_q)
      idle_d = idle_q;

    arb_d = arb_q;
    if (scl_rise_o && busy_q && !core_sda_pull && !sda_f_q) arb_d = 1'b1;
    else if (arb_clr_i)                                    arb_d = 1'b0;

    // Counts against the next filtered SCL so the flag drops with the release edge
    str_cnt_d = '0;
    if (!core_scl_pull && !scl_f_d)
      str_cnt_d = (str_cnt_q != '1) ? str_cnt_q + (FILT_W+2)'(1) : str_cnt_q;
    stretch_d = str_cnt_d > str_thr;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_s1_q  <= 1'b1;
      scl_s2_q  <= 1'b1;
      sda_s1_q  <= 1'b1;
      sda_s2_q  <= 1'b1;
      scl_f_q   <= 1'b1;
      sda_f_q   <= 1'b1;
      scl_c_q   <= '0;
      sda_c_q   <= '0;
      scl_dly_q <= 1'b1;
      sda_dly_q <= 1'b1;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      idle_q    <= '0;
      arb_q     <= 1'b0;
      str_cnt_q <= '0;
      stretch_q <= 1'b0;
    end else begin
      scl_s1_q  <= scl_s1_d;
      scl_s2_q  <= scl_s2_d;
      sda_s1_q  <= sda_s1_d;
      sda_s2_q  <= sda_s2_d;
      scl_f_q   <= scl_f_d;
      sda_f_q   <= sda_f_d;
      scl_c_q   <= scl_c_d;
      sda_c_q   <= sda_c_d;
      scl_dly_q <= scl_dly_d;
      sda_dly_q <= sda_dly_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      idle_q    <= idle_d;
      arb_q     <= arb_d;
      str_cnt_q <= str_cnt_d;
      stretch_q <= stretch_d;
    end
  end

  assign scl_o      = scl_f_q;
  assign sda_o      = sda_f_q;
  assign busy_o     = busy_q;
  assign timeout_o  = timeout_q;
  assign arb_lost_o = arb_q;
  assign stretch_o  = stretch_q;

endmodule

// File: tb/tb_i2c_line_cond.sv
// Randomised bench for i2c_line_cond against a cycle-level behavioural model,
// plus directed filter, timeout, arbitration and stretch scenarios.
module tb_i2c_line_cond;
  localparam int unsigned FW = 4;
  localparam int unsigned IW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic scl_pad = 1'b1, sda_pad = 1'b1;
  logic scl_oe = 1'b0, scl_dat = 1'b1, sda_oe = 1'b0, sda_dat = 1'b1;
  logic [FW-1:0] filt = '0;
  logic [IW-1:0] tmo = '0;
  logic arb_clr = 1'b0;
  logic scl_o, sda_o, start_o, stop_o, scl_rise_o, scl_fall_o;
  logic busy_o, timeout_o, arb_lost_o, stretch_o;

  always #5 clk = ~clk;

  i2c_line_cond #(.FILT_W(FW), .IDLE_W(IW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .scl_pad_i(scl_pad), .sda_pad_i(sda_pad),
    .scl_oe_i(scl_oe), .scl_dat_i(scl_dat), .sda_oe_i(sda_oe), .sda_dat_i(sda_dat),
    .filt_len_i(filt), .idle_tmo_i(tmo), .arb_clr_i(arb_clr),
    .scl_o(scl_o), .sda_o(sda_o), .start_o(start_o), .stop_o(stop_o),
    .scl_rise_o(scl_rise_o), .scl_fall_o(scl_fall_o), .busy_o(busy_o),
    .timeout_o(timeout_o), .arb_lost_o(arb_lost_o), .stretch_o(stretch_o)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: sync is a two-deep pad history, a line flips after filt+1
  // consecutive disagreeing samples, counters are plain integers.
  bit m_ss[2], m_sd[2];
  bit m_scl, m_sda, m_scl_d, m_sda_d;
  int m_run_scl, m_run_sda;
  bit m_busy, m_tout, m_arb, m_strch;
  int m_idle, m_str;

  task automatic m_reset;
    m_ss[0] = 1; m_ss[1] = 1; m_sd[0] = 1; m_sd[1] = 1;
    m_scl = 1; m_sda = 1; m_scl_d = 1; m_sda_d = 1;
    m_run_scl = 0; m_run_sda = 0;
    m_busy = 0; m_tout = 0; m_arb = 0; m_strch = 0;
    m_idle = 0; m_str = 0;
  endtask

  task automatic filt_line(input bit s, inout bit f, inout int run);
    if (s == f) run = 0;
    else begin
      run++;
      if (run == int'(filt) + 1) begin
        f = s;
        run = 0;
      end
    end
  endtask

  function automatic bit ev_start();  return m_scl_d && m_scl && m_sda_d && !m_sda; endfunction
  function automatic bit ev_stop();   return m_scl_d && m_scl && !m_sda_d && m_sda; endfunction
  function automatic bit ev_rise();   return !m_scl_d && m_scl; endfunction
  function automatic bit ev_fall();   return m_scl_d && !m_scl; endfunction

  task automatic m_step;
    bit st, sp, hit, set, nscl, nsda;
    int rs, rd;
    st  = ev_start();
    sp  = ev_stop();
    hit = m_busy && (tmo != 0) && (m_idle == int'(tmo) - 1);
    set = ev_rise() && m_busy && !(sda_oe && !sda_dat) && !m_sda;
    m_idle = (hit || !(m_scl && m_sda) || !m_busy) ? 0 : m_idle + 1;
    m_tout = hit;
    if (st) m_busy = 1;
    else if (sp || hit) m_busy = 0;
    if (set) m_arb = 1;
    else if (arb_clr) m_arb = 0;
    nscl = m_scl; rs = m_run_scl; filt_line(m_ss[1], nscl, rs);
    nsda = m_sda; rd = m_run_sda; filt_line(m_sd[1], nsda, rd);
    m_scl_d = m_scl; m_sda_d = m_sda;
    m_scl = nscl; m_sda = nsda; m_run_scl = rs; m_run_sda = rd;
    m_ss[1] = m_ss[0]; m_ss[0] = scl_pad;
    m_sd[1] = m_sd[0]; m_sd[0] = sda_pad;
    m_str   = (!(scl_oe && !scl_dat) && !m_scl) ? m_str + 1 : 0;
    m_strch = m_str > int'(filt) + 3;
  endtask

  task automatic check_all;
    chk("scl_o", scl_o, m_scl);
    chk("sda_o", sda_o, m_sda);
    chk("start", start_o, ev_start());
    chk("stop", stop_o, ev_stop());
    chk("rise", scl_rise_o, ev_rise());
    chk("fall", scl_fall_o, ev_fall());
    chk("busy", busy_o, m_busy);
    chk("timeout", timeout_o, m_tout);
    chk("arb_lost", arb_lost_o, m_arb);
    chk("stretch", stretch_o, m_strch);
  endtask

  task automatic tick;
    @(posedge clk);
    if (rst_n) m_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic rhold(input int n);
    repeat (n) begin
      arb_clr = ($urandom_range(0, 9) == 0);
      tick();
    end
    arb_clr = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    m_reset();
    #1;
    check_all();
    hold(3);
    rst_n = 1'b1;
  endtask

  int fall_at, k, low_cnt, rise_at;
  bit seen, prev_str, done;

  initial begin
    #2;
    // Reset with pads high: quiet for 20 cycles after release
    filt = FW'(3);
    do_reset();
    repeat (20) begin
      tick();
      chk("rst_quiet", {start_o, stop_o, scl_rise_o, scl_fall_o}, 0);
    end

    // Glitch rejection and filter latency
    sda_pad = 1'b0; hold(3); sda_pad = 1'b1;
    repeat (10) begin tick(); chk("glitch_rej", sda_o, 1); end
    sda_pad = 1'b0;
    fall_at = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 5) sda_pad = 1'b1;
      if (!sda_o && fall_at == 0) fall_at = i;
    end
    chk("filt_latency", fall_at, 6);
    hold(12);

    // Idle timeout of 10 cycles
    filt = '0; tmo = IW'(10);
    do_reset();
    sda_pad = 1'b0; hold(5);
    chk("busy_after_start", busy_o, 1);
    scl_pad = 1'b0; hold(5);
    sda_pad = 1'b1; hold(5);
    scl_pad = 1'b1;
    seen = 0; k = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (seen) begin
        k++;
        if (!busy_o) begin
          chk("tmo_pulse", timeout_o, 1);
          done = 1;
        end
      end else if (scl_o) seen = 1;
    end
    chk("tmo_cycles", done ? k : -1, 10);
    tick();
    chk("tmo_one_shot", timeout_o, 0);

    // Timeout disabled: bus stays busy
    tmo = '0;
    sda_pad = 1'b0; hold(5);
    scl_pad = 1'b0; hold(5);
    sda_pad = 1'b1; hold(5);
    scl_pad = 1'b1; hold(30);
    chk("no_tmo_busy", busy_o, 1);

    // Arbitration loss, clear, and clear coinciding with a new loss
    sda_oe = 1'b0;
    scl_pad = 1'b0; hold(4);
    sda_pad = 1'b0; hold(4);
    scl_pad = 1'b1; hold(4);
    chk("arb_set", arb_lost_o, 1);
    hold(10);
    chk("arb_sticky", arb_lost_o, 1);
    arb_clr = 1'b1; tick(); arb_clr = 1'b0; tick();
    chk("arb_clr", arb_lost_o, 0);
    scl_pad = 1'b0; hold(4);
    scl_pad = 1'b1;
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      if (scl_rise_o) begin
        arb_clr = 1'b1; tick(); arb_clr = 1'b0;
        chk("arb_set_wins", arb_lost_o, 1);
        done = 1;
      end
    end
    chk("arb_rise_seen", done, 1);

    // Remote clock stretch with filter length 0
    do_reset();
    scl_oe = 1'b0;
    scl_pad = 1'b0;
    low_cnt = 0; rise_at = 0; prev_str = 0; done = 0;
    for (int i = 1; i <= 25 && !done; i++) begin
      tick();
      if (i == 10) scl_pad = 1'b1;
      if (!scl_o) begin
        low_cnt++;
        if (stretch_o && rise_at == 0) rise_at = low_cnt;
      end else if (low_cnt > 0) begin
        chk("stretch_fall", stretch_o, 0);
        chk("stretch_was_high", prev_str, 1);
        done = 1;
      end
      prev_str = stretch_o;
    end
    chk("stretch_rise", rise_at, 4);
    chk("stretch_release", done, 1);

    // Randomised bus activity
    for (int p = 0; p < 12; p++) begin
      filt = FW'($urandom_range(0, 4));
      tmo  = ($urandom_range(0, 2) == 0) ? '0 : IW'($urandom_range(3, 30));
      do_reset();
      for (int s = 0; s < 40; s++) begin
        if ($urandom_range(0, 39) == 0) do_reset();
        case ($urandom_range(0, 5))
          0: begin scl_pad = ~scl_pad; rhold($urandom_range(1, int'(filt) + 8)); end
          1: begin sda_pad = ~sda_pad; rhold($urandom_range(1, int'(filt) + 8)); end
          2: begin
            scl_pad = ~scl_pad; sda_pad = ~sda_pad;
            rhold($urandom_range(1, int'(filt) + 8));
          end
          3: begin
            if ($urandom_range(0, 1) == 0) begin
              scl_pad = ~scl_pad; rhold($urandom_range(1, int'(filt) + 2)); scl_pad = ~scl_pad;
            end else begin
              sda_pad = ~sda_pad; rhold($urandom_range(1, int'(filt) + 2)); sda_pad = ~sda_pad;
            end
            rhold($urandom_range(1, 6));
          end
          4: rhold($urandom_range(10, 50));
          default: begin
            scl_oe = 1'($urandom); scl_dat = 1'($urandom);
            sda_oe = 1'($urandom); sda_dat = 1'($urandom);
            rhold($urandom_range(1, 4));
          end
        endcase
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
